glb_weight_router: RTL and testbench
====================================

Name: glb_weight_router

Overview:
- Weight global buffer (GLB) bank with a built-in weight router.
- Software or the testbench fills the GLB through a write port.
- A one-shot load command from the control unit streams kernel_size*kernel_size weights from the GLB into a PE scratchpad (spad), one word per cycle.
- Sits between the GLB cluster and a PE in the hierarchical-mesh NoC.

Parameters:
- DATA_BITWIDTH, 16, width of weight words.
- ADDR_BITWIDTH_GLB, 10, GLB address width; depth is 2^10 words.
- ADDR_BITWIDTH_SPAD, 9, spad address width.
- kernel_size, 3, filter edge; transfer length N = kernel_size*kernel_size.
- act_size, 5, activation edge; reserved, no effect on behaviour.
- W_READ_ADDR, 0, first GLB address read.
- W_LOAD_ADDR, 0, first spad address written.
- PSUM_READ_ADDR, 500, reserved, unused.
- PSUM_LOAD_ADDR, 0, reserved, unused.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en_wght  in  1  GLB write enable.
- w_addr_wght  in  ADDR_BITWIDTH_GLB  GLB write address.
- w_data_wght  in  DATA_BITWIDTH  GLB write data.
- load_spad_ctrl  in  1  start command from the control unit (level-sampled).
- w_data_spad  out  DATA_BITWIDTH  weight word sent to the spad.
- w_addr_spad  out  ADDR_BITWIDTH_SPAD  spad write address.
- load_en_spad  out  1  spad write strobe; data and address are valid while it is high.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset forces the FSM to IDLE and all counters to 0. It drives w_data_spad=0, w_addr_spad=0, load_en_spad=0, busy=0 and done=0.
- GLB contents are not cleared by reset.
- GLB write: on an edge with write_en_wght=1, mem[w_addr_wght] <= w_data_wght.
- GLB read: internal and synchronous, one-cycle latency.
- Same-address write and read in one cycle: read-before-write, the read returns the old value.
- FSM states are IDLE, LOAD, DONE.
- IDLE -> LOAD: on an edge where load_spad_ctrl=1. Read index rd and write index wr clear to 0; busy goes high.
- In LOAD, each cycle with rd<N:
  - issue a read at GLB address (W_READ_ADDR+rd), truncated modulo 2^ADDR_BITWIDTH_GLB;
  - rd increments.
- One cycle after each read (registered outputs):
  - load_en_spad=1;
  - w_data_spad = the read data;
  - w_addr_spad = (W_LOAD_ADDR+wr), truncated modulo 2^ADDR_BITWIDTH_SPAD;
  - wr increments.
- Timing: if load_spad_ctrl is sampled at edge T0, load_en_spad is high for exactly N consecutive cycles, the first registered at edge T0+2. No gaps.
- LOAD -> DONE after the N-th spad write. In DONE, done=1 for one cycle and busy=0, then the FSM returns to IDLE.
- load_en_spad=0 in every cycle outside the N-cycle burst. w_data_spad and w_addr_spad hold their last values.
- load_spad_ctrl is ignored in LOAD and DONE. A level held high across several cycles starts only one transfer.
- A new start is accepted in IDLE the cycle after done; a level still high then does start a second transfer.
- Reset asserted during LOAD aborts immediately with no further spad writes. A later start restarts from W_READ_ADDR and W_LOAD_ADDR.
- GLB writes are permitted during a transfer and follow the read-before-write rule.
- N is fixed by parameter; kernel_size >= 1 is required.

Test Plan:
- Load and stream: write values 1..9 to GLB addresses 0..8, then pulse load_spad_ctrl for 1 cycle.
  - Expect load_en_spad high for 9 consecutive cycles starting 2 edges later.
  - Expect w_data_spad = 1..9 and w_addr_spad = 0..8.
  - Expect a done pulse on the following cycle, and busy high throughout the transfer.
- Long start: hold load_spad_ctrl high for 2 cycles -> exactly one 9-word burst.
- Start while busy: raise load_spad_ctrl again mid-burst -> no effect; the burst stays at 9 words.
- Reset mid-transfer: assert reset after the 3rd spad write.
  - Expect load_en_spad=0 and busy=0 from the next cycle.
  - A new start reproduces data 1..9 and addresses 0..8.
- Address wrap: with W_READ_ADDR=1020 and W_LOAD_ADDR=510, preload GLB so mem[a] = a.
  - Expect GLB reads at 1020..1023 then 0..4.
  - Expect spad addresses 510, 511, 0..6.
- Collision: write 0xBEEF to address 4 in the same cycle the router reads address 4 (old value 5) -> w_data_spad=5 for that word.

Source files
------------

// File: rtl/glb_weight_router.sv
// Weight GLB bank with a built-in router. The GLB is filled through a write
// port; a start command streams kernel_size*kernel_size consecutive words
// from the GLB into a PE scratchpad, one word per cycle.
module glb_weight_router #(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_GLB  = 10,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int kernel_size        = 3,
  parameter int act_size           = 5,
  parameter int W_READ_ADDR        = 0,
  parameter int W_LOAD_ADDR        = 0,
  parameter int PSUM_READ_ADDR     = 500,
  parameter int PSUM_LOAD_ADDR     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en_wght,
  input  logic [ADDR_BITWIDTH_GLB-1:0]  w_addr_wght,
  input  logic [DATA_BITWIDTH-1:0]      w_data_wght,
  input  logic                          load_spad_ctrl,
  output logic [DATA_BITWIDTH-1:0]      w_data_spad,
  output logic [ADDR_BITWIDTH_SPAD-1:0] w_addr_spad,
  output logic                          load_en_spad,
  output logic                          busy,
  output logic                          done
);

  localparam int N     = kernel_size * kernel_size;
  localparam int CNT_W = $clog2(N + 1);
  localparam int DEPTH = 1 << ADDR_BITWIDTH_GLB;

  // Parameter sanity; the reserved parameters only need to be well-formed.
  if (kernel_size < 1) begin : g_bad_kernel
    $error("glb_weight_router: kernel_size must be >= 1");
  end
  if (act_size < 1 || PSUM_READ_ADDR < 0 || PSUM_LOAD_ADDR < 0) begin : g_bad_reserved
    $error("glb_weight_router: reserved parameters out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              rd_q;
  logic [CNT_W-1:0]              wr_q;
  logic                          rvalid_q;
  logic [DATA_BITWIDTH-1:0]      rdata_q;
  logic [DATA_BITWIDTH-1:0]      mem_q [DEPTH];

  logic                          rd_en_d;
  logic [ADDR_BITWIDTH_GLB-1:0]  rd_addr_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] wr_addr_d;

  // Read strobe and wrapped GLB / spad addresses for the current indices.
  always_comb begin
    rd_en_d   = (state_q == LOAD) && (rd_q < CNT_W'(N));
    rd_addr_d = ADDR_BITWIDTH_GLB'(W_READ_ADDR + int'(rd_q));
    wr_addr_d = ADDR_BITWIDTH_SPAD'(W_LOAD_ADDR + int'(wr_q));
  end

  // GLB storage: write port plus one-cycle synchronous read port.
  // NOTE: the array has no reset on purpose; contents survive reset and
  // an unreset array maps onto block RAM. Both accesses use non-blocking
  // assignments, so a same-address read in the write cycle sees the old word.
  always_ff @(posedge clk) begin
    if (write_en_wght) mem_q[w_addr_wght] <= w_data_wght;
    if (rd_en_d)       rdata_q <= mem_q[rd_addr_d];
  end

  // Transfer FSM with registered spad outputs, busy and done.
  // NOTE: all state here is updated with <= so every branch sees the
  // pre-edge values of rd_q, wr_q and rvalid_q regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      wr_q         <= '0;
      rvalid_q     <= 1'b0;
      w_data_spad  <= '0;
      w_addr_spad  <= '0;
      load_en_spad <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rvalid_q     <= rd_en_d;
      load_en_spad <= 1'b0;
      done         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_spad_ctrl) begin
            state_q <= LOAD;
            rd_q    <= '0;
            wr_q    <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (rd_en_d) rd_q <= rd_q + CNT_W'(1);
          // Forward last cycle's read to the spad.
          if (rvalid_q) begin
            load_en_spad <= 1'b1;
            w_data_spad  <= rdata_q;
            w_addr_spad  <= wr_addr_d;
            wr_q         <= wr_q + CNT_W'(1);
            if (wr_q == CNT_W'(N - 1)) state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_weight_router.sv
// Bench for glb_weight_router: a default instance and an instance with
// wrapping base addresses. Expected spad words are queued when a burst is
// launched and popped as load_en_spad beats appear; control timing is
// checked cycle by cycle relative to the start edge.
module tb_glb_weight_router;

  localparam int NK = 9;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  a;
  } exp_t;

  logic clk;
  logic reset;

  logic        we0, we1;
  logic [9:0]  wa0, wa1;
  logic [15:0] wd0, wd1;
  logic        ld0, ld1;
  logic [15:0] d0, d1;
  logic [8:0]  a0, a1;
  logic        le0, le1, busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [15:0] model0 [1024];
  logic [15:0] model1 [1024];

  glb_weight_router u_dut (
    .clk(clk), .reset(reset),
    .write_en_wght(we0), .w_addr_wght(wa0), .w_data_wght(wd0),
    .load_spad_ctrl(ld0),
    .w_data_spad(d0), .w_addr_spad(a0), .load_en_spad(le0),
    .busy(busy0), .done(done0)
  );

  glb_weight_router #(.W_READ_ADDR(1020), .W_LOAD_ADDR(510)) u_wrap (
    .clk(clk), .reset(reset),
    .write_en_wght(we1), .w_addr_wght(wa1), .w_data_wght(wd1),
    .load_spad_ctrl(ld1),
    .w_data_spad(d1), .w_addr_spad(a1), .load_en_spad(le1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected word per strobe.
  always @(negedge clk) begin
    if (le0 === 1'b1) begin
      if (q0.size() == 0) check("dut0_unexpected_beat", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0_w_data_spad", 32'(d0), 32'(e0.d));
        check("dut0_w_addr_spad", 32'(a0), 32'(e0.a));
      end
    end
  end

  always @(negedge clk) begin
    if (le1 === 1'b1) begin
      if (q1.size() == 0) check("wrap_unexpected_beat", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("wrap_w_data_spad", 32'(d1), 32'(e1.d));
        check("wrap_w_addr_spad", 32'(a1), 32'(e1.a));
      end
    end
  end

  task automatic glb_write(input int sel, input logic [9:0] addr, input logic [15:0] data);
    if (sel == 0) begin we0 = 1'b1; wa0 = addr; wd0 = data; model0[addr] = data; end
    else          begin we1 = 1'b1; wa1 = addr; wd1 = data; model1[addr] = data; end
    @(posedge clk);
    #1;
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  // Launch one transfer and check control outputs for 13 cycles after the
  // start edge T0. hold: cycles load_spad_ctrl stays high from T0; poke: cycle
  // index of an extra one-cycle start pulse; rst_k: cycle index at which
  // reset is raised for one edge; col_k: cycle index at which 0xBEEF is
  // written to address 4. Negative values disable an option.
  task automatic run_burst(input int sel, input int hold, input int poke,
                           input int rst_k, input int col_k, input string name);
    logic le, bz, dn;
    logic exp_le, exp_bz, exp_dn;
    bit   aborted;
    int   left;
    for (int i = 0; i < NK; i++) begin
      if (sel == 0) q0.push_back('{d: model0[10'(i)], a: 9'(i)});
      else          q1.push_back('{d: model1[10'(1020 + i)], a: 9'(510 + i)});
    end
    #1;
    if (sel == 0) ld0 = 1'b1; else ld1 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 12; k++) begin
      #1;
      if (sel == 0) ld0 = (k + 1 < hold) || (k == poke);
      else          ld1 = (k + 1 < hold) || (k == poke);
      if (k == rst_k)          reset = 1'b1;
      else if (k == rst_k + 1) reset = 1'b0;
      if (col_k >= 0) begin
        if (k == col_k) begin we0 = 1'b1; wa0 = 10'd4; wd0 = 16'hBEEF; end
        else we0 = 1'b0;
      end
      @(negedge clk);
      le = (sel == 0) ? le0 : le1;
      bz = (sel == 0) ? busy0 : busy1;
      dn = (sel == 0) ? done0 : done1;
      aborted = (rst_k >= 0) && (k > rst_k);
      exp_le  = !aborted && (k >= 2) && (k <= 10);
      exp_bz  = !aborted && (k <= 10);
      exp_dn  = !aborted && (k == 11);
      check($sformatf("%s_load_en_k%0d", name, k), 32'(le), 32'(exp_le));
      check($sformatf("%s_busy_k%0d", name, k), 32'(bz), 32'(exp_bz));
      check($sformatf("%s_done_k%0d", name, k), 32'(dn), 32'(exp_dn));
      @(posedge clk);
    end
    left = (sel == 0) ? q0.size() : q1.size();
    check({name, "_words_left"}, 32'(left), (rst_k >= 0) ? 32'(NK - 3) : 32'd0);
    q0.delete();
    q1.delete();
    if (col_k >= 0) model0[4] = 16'hBEEF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0; ld0 = 1'b0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; ld1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_w_data_spad", 32'(d0), 32'd0);
    check("rst_w_addr_spad", 32'(a0), 32'd0);
    check("rst_load_en",     32'(le0), 32'd0);
    check("rst_busy",        32'(busy0), 32'd0);
    check("rst_done",        32'(done0), 32'd0);
    check("rst_wrap_data",   32'(d1), 32'd0);
    check("rst_wrap_addr",   32'(a1), 32'd0);
    check("rst_wrap_load",   32'(le1), 32'd0);
    check("rst_wrap_busy",   32'(busy1), 32'd0);
    check("rst_wrap_done",   32'(done1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int a = 0; a < NK; a++) glb_write(0, 10'(a), 16'(a + 1));
    for (int a = 1020; a < 1024; a++) glb_write(1, 10'(a), 16'(a));
    for (int a = 0; a < 5; a++) glb_write(1, 10'(a), 16'(a));

    run_burst(0, 1, -1, -1, -1, "basic");
    run_burst(0, 2, -1, -1, -1, "long_start");
    run_burst(0, 1,  5, -1, -1, "start_busy");
    run_burst(0, 1, -1,  4, -1, "reset_abort");
    run_burst(0, 1, -1, -1, -1, "restart");
    run_burst(1, 1, -1, -1, -1, "wrap");
    run_burst(0, 1, -1, -1,  4, "collision");
    run_burst(0, 1, -1, -1, -1, "after_collision");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
